// File: rtl/morse_tx.sv
// Morse letter transmitter: takes one letter per valid/ready handshake and keys
// led_o with dot/dash/gap timing built from a programmable unit period.
module morse_tx #(
  parameter int MAX_LEN          = 5,
  parameter int UNIT_CYCLES      = 25,
  parameter int DASH_UNITS       = 3,
  parameter int LETTER_GAP_UNITS = 3,
  parameter int LW               = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [MAX_LEN-1:0] code_i,
  input  logic [LW-1:0]      len_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               abort_i,
  output logic               led_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int UW   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int MAXU = (DASH_UNITS > LETTER_GAP_UNITS) ? DASH_UNITS : LETTER_GAP_UNITS;
  localparam int NW   = (MAXU > 1) ? $clog2(MAXU) : 1;

  localparam logic [UW-1:0] U_LAST    = UW'(UNIT_CYCLES - 1);
  localparam logic [NW-1:0] DASH_LAST = NW'(DASH_UNITS - 1);
  localparam logic [NW-1:0] LGAP_LAST = NW'(LETTER_GAP_UNITS - 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, MARK, GAP, LGAP} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] code_q;
  logic [LW-1:0]      len_q;
  logic [LW-1:0]      ptr;
  logic [UW-1:0]      ucnt;
  logic [NW-1:0]      ncnt;

  logic [LW-1:0] len_acc;
  logic [LW-1:0] ptr_inc;
  logic          sym_dash;

  assign len_acc  = (len_i > LEN_MAX) ? LEN_MAX : len_i;
  assign ptr_inc  = ptr + LW'(1);
  assign sym_dash = |(code_q & (MAX_LEN'(1) << ptr));

  assign ready_o = (state == IDLE);
  assign busy_o  = ~ready_o;
  assign led_o   = (state == MARK);

  function automatic logic [NW-1:0] sym_last(input logic dash);
    return dash ? DASH_LAST : '0;
  endfunction

  // ucnt counts cycles within a unit, ncnt counts remaining units of the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      code_q <= '0;
      len_q  <= '0;
      ptr    <= '0;
      ucnt   <= U_LAST;
      ncnt   <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (state == IDLE) begin
        if (valid_i) begin
          code_q <= code_i;
          len_q  <= len_acc;
          ptr    <= '0;
          ucnt   <= U_LAST;
          if (len_acc != '0) begin
            state <= MARK;
            ncnt  <= sym_last(code_i[0]);
          end else begin
            state <= LGAP;
            ncnt  <= LGAP_LAST;
          end
        end
      end else if (abort_i) begin
        state <= IDLE;
        ucnt  <= U_LAST;
        ncnt  <= '0;
      end else if (ucnt != '0) begin
        ucnt <= ucnt - UW'(1);
      end else begin
        ucnt <= U_LAST;
        if (ncnt != '0) begin
          ncnt <= ncnt - NW'(1);
        end else begin
          case (state)
            MARK: begin
              ptr <= ptr_inc;
              if (ptr_inc < len_q) begin
                state <= GAP;
                ncnt  <= '0;
              end else begin
                state <= LGAP;
                ncnt  <= LGAP_LAST;
              end
            end
            GAP: begin
              state <= MARK;
              ncnt  <= sym_last(sym_dash);
            end
            default: begin
              state  <= IDLE;
              done_o <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/morse_tx.md
# morse_tx

Parametrised Morse letter transmitter: accepts one letter per valid/ready handshake and keys `led_o` with standard Morse timing (dot, dash, inter-element gap, inter-letter gap) derived from a configurable unit period. It is the next-generation successor of the fixed 3-switch encoder. Its timing counter is internal, symbol length and unit period are generic, and the handshake allows an upstream source (switch LUT, UART or ROM sequencer) to stream letters back to back.

## Interface

- `MAX_LEN`, default 5: maximum symbols per letter, ≥1.
- `UNIT_CYCLES`, default 25: clock cycles per Morse unit (dot length), ≥1.
- `DASH_UNITS`, default 3: dash length in units, ≥1.
- `LETTER_GAP_UNITS`, default 3: trailing gap after the last symbol, in units, ≥1.
- `LW`, derived: `$clog2(MAX_LEN+1)`.

Ports:

- `clk_i` in 1: single clock; all logic on its rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `code_i` in MAX_LEN: symbol bits; bit 0 is sent first; 1 = dash, 0 = dot.
- `len_i` in LW: number of symbols to send.
- `valid_i` in 1: letter request.
- `ready_o` out 1: block can accept a letter.
- `abort_i` in 1: synchronous abort of the current letter.
- `led_o` out 1: key output; 1 = mark.
- `busy_o` out 1: letter in progress; equals ~`ready_o`.
- `done_o` out 1: one-cycle pulse when a letter completes normally.

## Operation

- States: IDLE, MARK, GAP, LGAP. State, code, length, symbol pointer, unit counter and cycle counter are all registers.
- `ready_o` = (state == IDLE). `led_o` = (state == MARK), decoded from the state register only, with no path from inputs.
- Accept: `valid_i & ready_o` at an edge.
  - Latch `code_i`, and latch `len_i` clamped to MAX_LEN.
  - Pointer is set to 0.
  - If len ≥ 1, enter MARK with the symbol-0 duration. If len = 0, enter LGAP.
- MARK: lasts `UNIT_CYCLES` × (1 for a dot, DASH_UNITS for a dash) cycles.
  - At the end, increment the pointer.
  - If pointer+1 < len, go to GAP; otherwise go to LGAP.
- GAP: lasts `UNIT_CYCLES` cycles (1 unit), then MARK for the symbol at the pointer.
- LGAP: lasts `UNIT_CYCLES` × LETTER_GAP_UNITS cycles, then IDLE with `done_o` = 1 in the first IDLE cycle.
- `code_i`, `len_i` and `valid_i` are ignored outside IDLE; later input changes do not affect a letter in flight.
- `abort_i` in MARK, GAP or LGAP: next state is IDLE and `led_o` drops next cycle. `done_o` is not pulsed. `abort_i` in IDLE has no effect.
  - If `abort_i` and `valid_i` are both high in IDLE, the letter is accepted.
- Counters:
  - Unit counter: `$clog2(UNIT_CYCLES)` bits (min 1), down-counting from UNIT_CYCLES-1. A tick occurs at 0.
  - Unit-count register: sized for max(DASH_UNITS, LETTER_GAP_UNITS).
  - No wrap-around is visible outside a state; both counters reload on every state entry.
- Reset (any time, including mid-letter) gives:
  - state IDLE, `led_o` = 0, `ready_o` = 1, `busy_o` = 0, `done_o` = 0;
  - pointer, code and length = 0.

## Timing

- Accept at edge 0 gives `led_o` = 1 from cycle 1. There is no extra pipeline latency.
- Letter duration is U × (Σ symbol units + (len−1) + LETTER_GAP_UNITS) cycles, where U = UNIT_CYCLES. `done_o` follows in the next cycle.
- IDLE lasts at least 1 cycle between letters. With `valid_i` held high, the next letter is accepted in that cycle.
- Letter-to-letter spacing is therefore U × LETTER_GAP_UNITS + 1 cycles of dark.
- `done_o` and `ready_o` rise in the same cycle.
- Every `led_o` mark is exactly U × k cycles for k ∈ {1, DASH_UNITS}. No glitches occur.

## Test plan

Common parameters: U=4, DASH_UNITS=3, LETTER_GAP_UNITS=3, MAX_LEN=5.

1. 'A' (`code_i`=5'b00010, `len_i`=2), accepted at cycle 0:
   - `led_o` high 1–4, low 5–8, high 9–20, low 21–32;
   - `done_o` = 1 and `ready_o` = 1 at cycle 33.
2. `len_i`=0, accepted at cycle 0: `led_o` stays 0; `done_o` pulses at cycle 13.
3. `valid_i` held high with 'E' (code 0, len 1):
   - marks at cycles 1–4, 18–21, 35–38;
   - `done_o` at 17, 34, 51.
4. `abort_i` at cycle 10 during 'A': `led_o` = 0 and `ready_o` = 1 from cycle 11; no `done_o`. A new letter accepted at cycle 11 starts marking at cycle 12.
5. `rst_i` asserted asynchronously mid-dash: `led_o` = 0 immediately and `ready_o` = 1. After release, 'T' (code 1, len 1) gives 12 mark cycles.
6. `len_i`=7 with MAX_LEN=5 and `code_i`=5'b11111: exactly 5 dashes of 12 cycles each, separated by 4-cycle gaps; `done_o` 13 cycles after the last mark ends.
